// File: rtl/amiq_stim_player.sv
// Multi-channel stimulus player: each channel replays a FIFO of (value, hold-delay)
// entries back-to-back on its slice of ch_out once playback is started.
module amiq_stim_player #(
    parameter int unsigned NOF_CH  = 3,
    parameter int unsigned DATA_W  = 1,
    parameter int unsigned DELAY_W = 8,
    parameter int unsigned DEPTH   = 32,
    localparam int unsigned CH_W   = (NOF_CH > 1) ? $clog2(NOF_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [CH_W-1:0]            wr_ch,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [DELAY_W-1:0]         wr_delay,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [NOF_CH*DATA_W-1:0]   ch_out,
    output logic [NOF_CH-1:0]          ch_active
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [DELAY_W-1:0] delay;
    } entry_t;

    entry_t                    r_mem [NOF_CH][DEPTH];
    logic [PW-1:0]             r_wp  [NOF_CH];
    logic [PW-1:0]             r_rp  [NOF_CH];
    logic [DELAY_W-1:0]        r_cnt [NOF_CH];
    logic [NOF_CH-1:0]         r_active;
    logic [NOF_CH*DATA_W-1:0]  r_ch_out;
    state_t                    r_state;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_err;

    entry_t                    w_head [NOF_CH];
    logic [NOF_CH-1:0]         w_empty;
    logic [NOF_CH-1:0]         w_full;
    logic [NOF_CH-1:0]         w_push;
    logic [NOF_CH-1:0]         w_load;
    logic [NOF_CH-1:0]         w_pop;
    logic                      w_ch_ok;
    logic                      w_sel_full;
    logic                      w_rdy;
    logic                      w_accept;
    logic                      w_start;

    // FIFO status, load handshake and per-channel pop decisions
    always_comb begin
        w_empty    = '0;
        w_full     = '0;
        w_push     = '0;
        w_load     = '0;
        w_pop      = '0;
        w_sel_full = 1'b0;
        w_ch_ok    = (32'(wr_ch) < NOF_CH);
        for (int c = 0; c < int'(NOF_CH); c++) begin
            w_head[c]  = r_mem[c][r_rp[c][AW-1:0]];
            w_empty[c] = (r_wp[c] == r_rp[c]);
            w_full[c]  = ((r_wp[c] - r_rp[c]) == PW'(DEPTH));
            if (CH_W'(c) == wr_ch) begin
                w_sel_full = w_full[c];
            end
        end
        w_rdy    = (r_state == S_IDLE) && !abort && (!w_ch_ok || !w_sel_full);
        w_accept = wr_valid && w_rdy;
        w_start  = (r_state == S_IDLE) && start && !abort;
        for (int c = 0; c < int'(NOF_CH); c++) begin
            w_push[c] = w_accept && w_ch_ok && (CH_W'(c) == wr_ch);
            w_load[c] = !abort && (w_start ||
                        ((r_state == S_RUN) && r_active[c] && (r_cnt[c] == DELAY_W'(1))));
            w_pop[c]  = w_load[c] && !w_empty[c];
        end
    end

    // Entry storage is not reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        for (int c = 0; c < int'(NOF_CH); c++) begin
            if (w_push[c]) begin
                r_mem[c][r_wp[c][AW-1:0]] <= {wr_data, wr_delay};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_active <= '0;
            r_ch_out <= '0;
            for (int c = 0; c < int'(NOF_CH); c++) begin
                r_wp[c]  <= '0;
                r_rp[c]  <= '0;
                r_cnt[c] <= '0;
            end
        end else if (abort) begin
            // Flush by catching read pointers up; ch_out keeps its last values
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_active <= '0;
            for (int c = 0; c < int'(NOF_CH); c++) begin
                r_rp[c]  <= r_wp[c];
                r_cnt[c] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (r_active == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            for (int c = 0; c < int'(NOF_CH); c++) begin
                if (w_pop[c]) begin
                    r_ch_out[c*DATA_W +: DATA_W] <= w_head[c].data;
                    r_cnt[c]    <= (w_head[c].delay == '0) ? DELAY_W'(1) : w_head[c].delay;
                    r_active[c] <= 1'b1;
                    r_rp[c]     <= r_rp[c] + PW'(1);
                end else if (w_load[c]) begin
                    r_active[c] <= 1'b0;
                    r_cnt[c]    <= '0;
                end else if (r_active[c] && (r_cnt[c] > DELAY_W'(1))) begin
                    r_cnt[c] <= r_cnt[c] - DELAY_W'(1);
                end
                if (w_push[c]) begin
                    r_wp[c] <= r_wp[c] + PW'(1);
                end
            end

            if (w_accept && !w_ch_ok) begin
                r_err <= 1'b1;
            end
        end
    end

    assign wr_ready  = w_rdy;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign ch_out    = r_ch_out;
    assign ch_active = r_active;

endmodule

// File: tb/tb_amiq_stim_player.sv
// Directed self-checking bench for amiq_stim_player (default parameters).
module tb_amiq_stim_player;

    localparam int unsigned NOF_CH  = 3;
    localparam int unsigned DATA_W  = 1;
    localparam int unsigned DELAY_W = 8;
    localparam int unsigned DEPTH   = 32;
    localparam int unsigned CH_W    = 2;

    logic                      clk;
    logic                      rst_n;
    logic                      wr_valid;
    logic                      wr_ready;
    logic [CH_W-1:0]           wr_ch;
    logic [DATA_W-1:0]         wr_data;
    logic [DELAY_W-1:0]        wr_delay;
    logic                      start;
    logic                      abort;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic [NOF_CH*DATA_W-1:0]  ch_out;
    logic [NOF_CH-1:0]         ch_active;

    int n_chk;
    int n_fail;

    amiq_stim_player #(
        .NOF_CH (NOF_CH),
        .DATA_W (DATA_W),
        .DELAY_W(DELAY_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_ch    (wr_ch),
        .wr_data  (wr_data),
        .wr_delay (wr_delay),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .ch_out   (ch_out),
        .ch_active(ch_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [1:0]  ch;
        logic        d;
        logic [7:0]  dl;
        logic        st;
        logic        ab;
        logic        rdy;
        logic [2:0]  out;
        logic [2:0]  act;
        logic        bsy;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] ch, input logic d, input logic [7:0] dl);
        wr_valid = 1'b1;
        wr_ch    = ch;
        wr_data  = d;
        wr_delay = dl;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int bad;
        int seen;
        n_chk    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_ch    = '0;
        wr_data  = '0;
        wr_delay = '0;
        start    = 1'b0;
        abort    = 1'b0;

        //              wv    ch     d     dl     st    ab    rdy   out     act     bsy   dn    er
        tbl[0]  = '{1'b1, 2'd0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 2'd0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 2'd0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 3'b001, 3'b001, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 2'd1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 2'd1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 2'd1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b010, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b010, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ch_out", 32'(ch_out), 32'd0);
        chk("rst_active", 32'(ch_active), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Per-cycle vectors: delay timing, zero-delay toggling, RUN-time load refusal
        for (int i = 0; i < 18; i++) begin
            wr_valid = tbl[i].wv;
            wr_ch    = tbl[i].ch;
            wr_data  = tbl[i].d;
            wr_delay = tbl[i].dl;
            start    = tbl[i].st;
            abort    = tbl[i].ab;
            #1;
            chk($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ch_out", i), 32'(ch_out), 32'(tbl[i].out));
            chk($sformatf("v%0d_active", i), 32'(ch_active), 32'(tbl[i].act));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].er));
        end
        wr_valid = 1'b0;
        start    = 1'b0;
        tick();

        // Fill ch2 to DEPTH, then check per-channel backpressure and replay length
        for (int i = 0; i < int'(DEPTH); i++) begin
            do_write(2'd2, 1'(i % 2), 8'd0);
        end
        wr_ch = 2'd2;
        #1;
        chk("full_ready_ch2", 32'(wr_ready), 32'd0);
        wr_ch = 2'd0;
        #1;
        chk("full_ready_ch0", 32'(wr_ready), 32'd1);
        do_write(2'd2, 1'b1, 8'd7);
        do_start();
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ch_out[2] !== 1'(i % 2) || ch_active[2] !== 1'b1) bad++;
            if (i < int'(DEPTH) - 1) tick();
        end
        chk("ch2_replay_errs", 32'(bad), 32'd0);
        tick();
        chk("ch2_len_active", 32'(ch_active), 32'd0);
        chk("ch2_len_busy", 32'(busy), 32'd1);
        tick();
        chk("ch2_done", 32'(done), 32'd1);
        chk("ch2_hold_out", 32'(ch_out), 32'b110);
        tick();

        // Abort mid-playback: flush, hold outputs, no done
        do_write(2'd0, 1'b1, 8'd200);
        do_write(2'd0, 1'b0, 8'd3);
        do_write(2'd1, 1'b1, 8'd5);
        do_start();
        chk("abort_pre_busy", 32'(busy), 32'd1);
        repeat (10) tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_active", 32'(ch_active), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ch_out", 32'(ch_out), 32'b111);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        wr_valid = 1'b1;
        wr_ch    = 2'd0;
        wr_data  = 1'b0;
        wr_delay = 8'd4;
        start    = 1'b1;
        abort    = 1'b1;
        #1;
        chk("abort_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        wr_valid = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        chk("abort_beats_start", 32'(busy), 32'd0);
        do_start();
        chk("empty_run_busy", 32'(busy), 32'd1);
        chk("empty_run_active", 32'(ch_active), 32'd0);
        tick();
        chk("empty_run_done", 32'(done), 32'd1);
        chk("empty_run_idle", 32'(busy), 32'd0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);

        // Invalid channel: accepted, sticky err, nothing stored
        wr_valid = 1'b1;
        wr_ch    = 2'd3;
        wr_data  = 1'b1;
        wr_delay = 8'd9;
        #1;
        chk("badch_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        chk("badch_err", 32'(err), 32'd1);
        do_start();
        chk("badch_active", 32'(ch_active), 32'd0);
        tick();
        chk("badch_done", 32'(done), 32'd1);
        tick();
        chk("badch_err_sticky", 32'(err), 32'd1);

        // Asynchronous reset mid-playback
        do_write(2'd0, 1'b0, 8'd50);
        do_write(2'd0, 1'b1, 8'd50);
        do_start();
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ch_out", 32'(ch_out), 32'd0);
        chk("arst_active", 32'(ch_active), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        do_start();
        chk("arst_start_busy", 32'(busy), 32'd1);
        chk("arst_start_active", 32'(ch_active), 32'd0);
        tick();
        chk("arst_start_done", 32'(done), 32'd1);
        chk("arst_final_out", 32'(ch_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
